// File: rtl/bcd_countdown_mod10.sv
// Multi-digit BCD down-counter with an internal prescaler.
// The counter is loaded with a start value and, while enabled, steps down
// once every PRESCALE enabled cycles. Each digit counts mod 10 and borrows
// from the digits above it. Done pulses once when a running count reaches 0.
//
// Handshake: there is no valid/ready pair. Load is a one-cycle command that
// takes effect on the next edge and overrides everything except Reset.
// Tick and Done are single-cycle pulses that are registered together with the
// Output value they describe.
module bcd_countdown_mod10 #(
   parameter int DIGITS   = 2,
   parameter int PRESCALE = 50_000_000,
   parameter int PS_W     = 26
) (
   input  logic                  clk_50M,
   input  logic                  Reset,
   input  logic                  Load,
   input  logic [4*DIGITS-1:0]   Load_value,
   input  logic                  Enable,
   output logic [4*DIGITS-1:0]   Output,
   output logic                  Tick,
   output logic                  Zero,
   output logic                  Done,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

   state_t                state, state_nxt;
   logic [PS_W-1:0]       ps_count, ps_nxt;
   logic [4*DIGITS-1:0]   count_nxt;
   logic [4*DIGITS-1:0]   clamp_value;
   logic [4*DIGITS-1:0]   dec_value;
   logic                  tick_nxt, done_nxt;
   logic                  step;
   logic                  borrow;
   logic [3:0]            load_digit;

   assign dbg_state = state;

   // A step happens on the edge where an enabled running prescaler wraps.
   assign step = (state == S_RUN) && Enable && (ps_count == PS_LAST);

   // Clamp every loaded digit above 9 down to 9.
   always_comb begin
      clamp_value = '0;
      load_digit  = '0;
      for (int k = 0; k < DIGITS; k++) begin
         load_digit = Load_value[4*k +: 4];
         clamp_value[4*k +: 4] = (load_digit > 4'd9) ? 4'd9 : load_digit;
      end
   end

   // Borrow-chained decrement: a digit moves only when all lower digits are 0.
   always_comb begin
      dec_value = Output;
      borrow    = 1'b1;
      for (int k = 0; k < DIGITS; k++) begin
         if (borrow) begin
            dec_value[4*k +: 4] = (Output[4*k +: 4] == 4'd0) ? 4'd9
                                                             : Output[4*k +: 4] - 4'd1;
         end
         borrow = borrow && (Output[4*k +: 4] == 4'd0);
      end
   end

   // State register plus the registered datapath outputs.
   always_ff @(posedge clk_50M) begin
      if (!Reset) begin
         state    <= S_IDLE;
         ps_count <= '0;
         Output   <= '0;
         Tick     <= 1'b0;
         Done     <= 1'b0;
         Zero     <= 1'b1;
      end else begin
         state    <= state_nxt;
         ps_count <= ps_nxt;
         Output   <= count_nxt;
         Tick     <= tick_nxt;
         Done     <= done_nxt;
         Zero     <= (count_nxt == '0);
      end
   end

   // Next-state logic; Load always returns to IDLE.
   always_comb begin
      state_nxt = state;
      if (Load) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE:  if (Enable && (Output != '0)) state_nxt = S_RUN;
            S_RUN:   if (step && (dec_value == '0)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   // Output/datapath next values: load, prescale advance, or count step.
   always_comb begin
      count_nxt = Output;
      ps_nxt    = ps_count;
      tick_nxt  = 1'b0;
      done_nxt  = 1'b0;
      if (Load) begin
         count_nxt = clamp_value;
         ps_nxt    = '0;
      end else if ((state == S_RUN) && Enable) begin
         if (step) begin
            ps_nxt    = '0;
            count_nxt = dec_value;
            tick_nxt  = 1'b1;
            done_nxt  = (dec_value == '0);
         end else begin
            ps_nxt = ps_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_bcd_countdown_mod10.sv
// Bench for bcd_countdown_mod10 with DIGITS=2, PRESCALE=4.
// An integer-valued model of the counter is compared with the DUT on every
// falling edge; directed steps add literal expectations and a queue of the
// values expected on each Tick.
module tb_bcd_countdown_mod10;

  localparam int DIGITS   = 2;
  localparam int PRESCALE = 4;
  localparam int PS_W     = 2;

  // ---------------- clock / reset ----------------
  logic       clk_50M = 1'b0;
  logic       Reset = 1'b0;
  logic       Load = 1'b0;
  logic       Enable = 1'b0;
  logic [7:0] Load_value = 8'h00;
  logic [7:0] Output;
  logic       Tick, Zero, Done;
  logic [1:0] dbg_state;

  always #10 clk_50M = ~clk_50M;

  bcd_countdown_mod10 #(
    .DIGITS(DIGITS), .PRESCALE(PRESCALE), .PS_W(PS_W)
  ) dut (
    .clk_50M(clk_50M), .Reset(Reset), .Load(Load), .Load_value(Load_value),
    .Enable(Enable), .Output(Output), .Tick(Tick), .Zero(Zero), .Done(Done),
    .dbg_state(dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         done_cnt = 0;
  int         tick_cnt = 0;
  bit         cmp_on = 1'b0;

  // model: count kept as a plain integer 0..99
  int m_val = 0;
  int m_mode = 0;   // 0 idle, 1 running, 2 finished
  int m_cnt = 0;    // enabled running cycles since last step
  bit m_tick = 1'b0;
  bit m_done = 1'b0;

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) * 16) + (v % 10));
  endfunction

  function automatic int clamp_int(input logic [7:0] lv);
    int hi, lo;
    hi = int'(lv[7:4]);
    lo = int'(lv[3:0]);
    if (hi > 9) hi = 9;
    if (lo > 9) lo = 9;
    return hi * 10 + lo;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // model update from the inputs seen at each rising edge
  always @(posedge clk_50M) begin
    if (!Reset) begin
      m_val <= 0; m_mode <= 0; m_cnt <= 0; m_tick <= 1'b0; m_done <= 1'b0;
    end else if (Load) begin
      m_val <= clamp_int(Load_value); m_mode <= 0; m_cnt <= 0;
      m_tick <= 1'b0; m_done <= 1'b0;
    end else begin
      m_tick <= 1'b0;
      m_done <= 1'b0;
      if (m_mode == 0) begin
        if (Enable && m_val != 0) m_mode <= 1;
      end else if (m_mode == 1 && Enable) begin
        if (m_cnt + 1 == PRESCALE) begin
          m_cnt  <= 0;
          m_val  <= m_val - 1;
          m_tick <= 1'b1;
          if (m_val == 1) begin
            m_done <= 1'b1;
            m_mode <= 2;
          end
        end else begin
          m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  // compare process: every falling edge once the bench is out of reset
  always @(negedge clk_50M) begin
    if (cmp_on) begin
      check("cyc_output", 32'(Output), 32'(to_bcd(m_val)));
      check("cyc_tick",   32'(Tick),   32'(m_tick));
      check("cyc_zero",   32'(Zero),   32'(m_val == 0));
      check("cyc_done",   32'(Done),   32'(m_done));
      if (Tick === 1'b1) begin
        tick_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tick_unexpected: got tick with output %0h, expected no tick", Output);
        end else begin
          check("tick_value", 32'(Output), 32'(exp_q.pop_front()));
        end
      end
      if (Done === 1'b1) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step_cyc();
    @(posedge clk_50M);
    #1;
  endtask

  task automatic do_load(input logic [7:0] v);
    Load = 1'b1;
    Load_value = v;
    step_cyc();
    Load = 1'b0;
  endtask

  task automatic wait_tick(input int max_cyc, output int n);
    n = -1;
    for (int i = 1; i <= max_cyc; i++) begin
      step_cyc();
      if (Tick === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  logic [7:0] count12 [12] = '{8'h11, 8'h10, 8'h09, 8'h08, 8'h07, 8'h06,
                               8'h05, 8'h04, 8'h03, 8'h02, 8'h01, 8'h00};
  int n;

  initial begin
    Reset = 1'b0;
    repeat (2) step_cyc();
    cmp_on = 1'b1;
    check("rst_output", 32'(Output), 32'h00);
    check("rst_zero",   32'(Zero),   32'd1);
    check("rst_tick",   32'(Tick),   32'd0);
    check("rst_done",   32'(Done),   32'd0);
    Reset = 1'b1;

    // full countdown from 12
    for (int i = 0; i < 12; i++) exp_q.push_back(count12[i]);
    done_cnt = 0;
    do_load(8'h12);
    check("load12", 32'(Output), 32'h12);
    check("load12_zero", 32'(Zero), 32'd0);
    Enable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step_cyc();
      if (Done === 1'b1) break;
    end
    check("done_seen", 32'(Done), 32'd1);
    check("final_output", 32'(Output), 32'h00);
    check("final_tick", 32'(Tick), 32'd1);
    check("final_zero", 32'(Zero), 32'd1);
    repeat (10) step_cyc();
    check("done_hold", 32'(Output), 32'h00);
    check("done_once", 32'(done_cnt), 32'd1);
    check("q_empty_12", 32'(exp_q.size()), 32'd0);

    // borrow: 10 -> 09
    exp_q.push_back(8'h09);
    do_load(8'h10);
    wait_tick(20, n);
    check("borrow", 32'(Output), 32'h09);

    // clamp, then zero load never starts
    Enable = 1'b0;
    do_load(8'h3F);
    check("clamp", 32'(Output), 32'h39);
    do_load(8'h00);
    tick_cnt = 0;
    Enable = 1'b1;
    repeat (20) step_cyc();
    check("zero_no_tick", 32'(tick_cnt), 32'd0);
    check("zero_flag", 32'(Zero), 32'd1);

    // first-step latency, then freeze mid-prescale and resume
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h03);
    do_load(8'h05);
    wait_tick(20, n);
    check("first_step_latency", 32'(n), 32'd5);
    repeat (2) step_cyc();
    Enable = 1'b0;
    tick_cnt = 0;
    repeat (10) step_cyc();
    check("freeze_output", 32'(Output), 32'h04);
    check("freeze_no_tick", 32'(tick_cnt), 32'd0);
    Enable = 1'b1;
    wait_tick(10, n);
    check("resume_latency", 32'(n), 32'd2);
    check("resume_output", 32'(Output), 32'h03);

    // load lands on the edge where a step would occur
    repeat (3) step_cyc();
    do_load(8'h27);
    check("load_on_tick_out",  32'(Output), 32'h27);
    check("load_on_tick_tick", 32'(Tick),   32'd0);
    check("load_on_tick_done", 32'(Done),   32'd0);

    // reset mid-run beats a simultaneous load
    repeat (3) step_cyc();
    Reset = 1'b0;
    Load = 1'b1;
    Load_value = 8'h55;
    step_cyc();
    check("reset_output", 32'(Output), 32'h00);
    check("reset_zero",   32'(Zero),   32'd1);
    Reset = 1'b1;
    Load = 1'b0;
    Enable = 1'b0;
    repeat (2) step_cyc();
    check("q_empty_end", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
